first_system_scheduler: RTL and testbench



---
 rtl/first_system_pkg.sv | 16 +
 rtl/first_system_rr_arbiter.sv | 48 ++++
 rtl/first_system_scheduler.sv | 143 ++++++++++++++
 tb/tb_first_system_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/first_system_pkg.sv
// first_system_pkg
//   Shared definitions for the first_system scheduler slice: default
//   parameter values and the scheduler FSM state encoding.
package first_system_pkg;

  localparam int NREQ_DEFAULT        = 4;
  localparam int ID_W_DEFAULT        = 2;
  localparam int EXEC_CYCLES_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/first_system_rr_arbiter.sv
// first_system_rr_arbiter
//   Purely combinational round-robin arbiter. Picks the first set request
//   bit searching upward from ptr, wrapping from NREQ-1 back to 0.
// Ports:
//   req            requester request vector
//   ptr            index of the highest-priority requester this round
//   winner_onehot  one-hot winner (all zero when no request)
//   winner_idx     binary index of the winner (0 when no request)
//   any_req        at least one request bit is set
module first_system_rr_arbiter
  import first_system_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int ID_W = ID_W_DEFAULT
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] winner_onehot,
  output logic [ID_W-1:0] winner_idx,
  output logic            any_req
);

  // Requests at or above the pointer take precedence; if none exist the
  // search wraps and the lowest set bit of the full vector wins.
  logic [NREQ-1:0] req_hi;
  logic [NREQ-1:0] req_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign req_hi[gi] = req[gi] & (32'(gi) >= 32'(ptr));
    end
  endgenerate

  always_comb begin
    any_req    = |req;
    req_sel    = (|req_hi) ? req_hi : req;
    winner_idx = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_sel[i]) begin
        winner_idx = ID_W'(i);
      end
    end
    winner_onehot = any_req ? (NREQ'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/first_system_scheduler.sv
// first_system_scheduler
//   Time-shares one first_system evaluation unit (out1 = in1 ^ in2,
//   out2 = ~in2) among NREQ requesters. Round-robin arbitration, one-cycle
//   one-hot grant, operand capture, EXEC_CYCLES of execution, then a
//   valid/ready result handshake tagged with the requester index.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req                 per-requester request
//   req_in1, req_in2    per-requester operands, held until gnt
//   gnt                 one-hot single-cycle grant (operands captured)
//   busy                scheduler not idle
//   rsp_valid/rsp_ready result handshake
//   rsp_id              requester index of the result
//   rsp_out1, rsp_out2  computed results
module first_system_scheduler
  import first_system_pkg::*;
#(
  parameter int NREQ        = NREQ_DEFAULT,
  parameter int ID_W        = ID_W_DEFAULT,
  parameter int EXEC_CYCLES = EXEC_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_in1,
  input  logic [NREQ-1:0] req_in2,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_out1,
  output logic            rsp_out2
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  state_t            state_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              op1_reg;
  logic              op2_reg;
  logic [ID_W-1:0]   id_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic              busy_reg;
  logic              rsp_valid_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              rsp_out1_reg;
  logic              rsp_out2_reg;

  logic [NREQ-1:0]   win_onehot;
  logic [ID_W-1:0]   win_idx;
  logic              any_req;
  logic              launch;
  logic [ID_W-1:0]   ptr_next;

  first_system_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req           (req),
    .ptr           (ptr_reg),
    .winner_onehot (win_onehot),
    .winner_idx    (win_idx),
    .any_req       (any_req)
  );

  // A new transaction starts from IDLE, or back-to-back from RESP on the
  // same edge the current result is accepted.
  always_comb begin
    launch   = any_req && ((state_reg == ST_IDLE) ||
                           ((state_reg == ST_RESP) && rsp_ready));
    ptr_next = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      op1_reg       <= 1'b0;
      op2_reg       <= 1'b0;
      id_reg        <= '0;
      gnt_reg       <= '0;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_out1_reg  <= 1'b0;
      rsp_out2_reg  <= 1'b0;
    end else begin
      gnt_reg <= '0;
      if (launch) begin
        gnt_reg       <= win_onehot;
        op1_reg       <= |(req_in1 & win_onehot);
        op2_reg       <= |(req_in2 & win_onehot);
        id_reg        <= win_idx;
        ptr_reg       <= ptr_next;
        cnt_reg       <= '0;
        state_reg     <= ST_EXEC;
        busy_reg      <= 1'b1;
        rsp_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            busy_reg <= 1'b0;
          end
          ST_EXEC: begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_LAST) begin
              rsp_out1_reg  <= op1_reg ^ op2_reg;
              rsp_out2_reg  <= ~op2_reg;
              rsp_id_reg    <= id_reg;
              rsp_valid_reg <= 1'b1;
              state_reg     <= ST_RESP;
            end
          end
          ST_RESP: begin
            // Result and tag stay frozen until the consumer takes them.
            if (rsp_ready) begin
              rsp_valid_reg <= 1'b0;
              state_reg     <= ST_IDLE;
              busy_reg      <= 1'b0;
            end
          end
          default: begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gnt       = gnt_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_out1  = rsp_out1_reg;
  assign rsp_out2  = rsp_out2_reg;

endmodule

// File: tb/tb_first_system_scheduler.sv
// tb_first_system_scheduler
//   Table-driven single transactions plus hand-written sequences for
//   fairness, backpressure and reset mid-transaction. Responses are checked
//   through a scoreboard queue filled when stimulus is driven.
module tb_first_system_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req_in1;
  logic [3:0] req_in2;
  logic [3:0] gnt;
  logic       busy;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic       rsp_out1;
  logic       rsp_out2;

  first_system_scheduler #(
    .NREQ        (4),
    .ID_W        (2),
    .EXEC_CYCLES (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out1  (rsp_out1),
    .rsp_out2  (rsp_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    logic       exp_o1;
    logic       exp_o2;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic       o1;
    logic       o2;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a result is consumed on any edge with valid & ready.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got id=%0d with empty scoreboard", rsp_id);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id",   32'(rsp_id),   32'(e.id));
          check("rsp_out1", 32'(rsp_out1), 32'(e.o1));
          check("rsp_out2", 32'(rsp_out2), 32'(e.o2));
          $display("txn id=%0d out1=%0d out2=%0d (exp id=%0d out1=%0d out2=%0d)",
                   rsp_id, rsp_out1, rsp_out2, e.id, e.o1, e.o2);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rsp_t model(input logic [3:0] i1, input logic [3:0] i2, input int w);
    rsp_t r;
    r.id = 2'(w);
    r.o1 = i1[w] ^ i2[w];
    r.o2 = ~i2[w];
    return r;
  endfunction

  // One isolated transaction with exact latency checks (called at a negedge).
  task automatic run_vec(input vec_t v);
    rsp_t e;
    req     = v.req;
    req_in1 = v.in1;
    req_in2 = v.in2;
    e.id = v.exp_id;
    e.o1 = v.exp_o1;
    e.o2 = v.exp_o2;
    sb_q.push_back(e);
    @(negedge clk);
    check("gnt",       32'(gnt),  32'(v.exp_gnt));
    check("busy_exec", 32'(busy), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    check("gnt_single_pulse",  32'(gnt),       32'd0);
    @(negedge clk);
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("busy_idle",      32'(busy),      32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [3:0] fair_in1;
    logic [3:0] fair_in2;
    logic [3:0] fair_gnt[5];
    int         fair_id[5];

    vecs[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1};
    vecs[2] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[3] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
    vecs[5] = '{4'b0011, 4'b0010, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[6] = '{4'b0101, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[7] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1};
    vecs[8] = '{4'b1001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[9] = '{4'b1001, 4'b0000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};

    fair_gnt[0] = 4'b0001; fair_gnt[1] = 4'b0010; fair_gnt[2] = 4'b0100;
    fair_gnt[3] = 4'b1000; fair_gnt[4] = 4'b0001;
    fair_id[0] = 0; fair_id[1] = 1; fair_id[2] = 2; fair_id[3] = 3; fair_id[4] = 0;

    rst_n     = 1'b0;
    req       = 4'b0000;
    req_in1   = 4'b0000;
    req_in2   = 4'b0000;
    rsp_ready = 1'b1;

    // Reset state
    #1;
    check("rst_gnt",       32'(gnt),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_out1",  32'(rsp_out1),  32'd0);
    check("rst_rsp_out2",  32'(rsp_out2),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: single transactions, truth table, pointer wrap
    for (int k = 0; k < 10; k++) begin
      run_vec(vecs[k]);
    end

    // Fairness: all four requesting, a grant every two cycles
    fair_in1 = 4'b1010;
    fair_in2 = 4'b0110;
    req      = 4'b1111;
    req_in1  = fair_in1;
    req_in2  = fair_in2;
    for (int k = 0; k < 5; k++) begin
      sb_q.push_back(model(fair_in1, fair_in2, fair_id[k]));
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        check("fair_gnt", 32'(gnt), 32'(fair_gnt[(c - 1) / 2]));
        if (c == 9) req = 4'b0000;
      end else begin
        check("fair_gnt_gap",   32'(gnt),       32'd0);
        check("fair_rsp_valid", 32'(rsp_valid), 32'd1);
      end
    end
    @(negedge clk);
    check("fair_busy_idle", 32'(busy), 32'd0);

    // Backpressure with a pending request
    rsp_ready = 1'b0;
    req       = 4'b0010;
    req_in1   = 4'b0010;
    req_in2   = 4'b0000;
    sb_q.push_back(model(4'b0010, 4'b0000, 1));
    @(negedge clk);
    check("bp_gnt1", 32'(gnt), 32'b0010);
    req = 4'b0000;
    @(negedge clk);
    check("bp_valid", 32'(rsp_valid), 32'd1);
    req     = 4'b0100;
    req_in1 = 4'b0000;
    req_in2 = 4'b0100;
    sb_q.push_back(model(4'b0000, 4'b0100, 2));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_id",    32'(rsp_id),    32'd1);
      check("bp_hold_out1",  32'(rsp_out1),  32'd1);
      check("bp_hold_out2",  32'(rsp_out2),  32'd1);
      check("bp_hold_gnt",   32'(gnt),       32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_gnt2",        32'(gnt),       32'b0100);
    check("bp_valid_clear", 32'(rsp_valid), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    check("bp_valid2", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("bp_busy_idle", 32'(busy), 32'd0);

    // Reset mid-EXEC: the in-flight transaction must vanish
    rsp_ready = 1'b0;
    req       = 4'b0001;
    req_in1   = 4'b0000;
    req_in2   = 4'b0000;
    @(negedge clk);
    check("mid_gnt",  32'(gnt),  32'b0001);
    check("mid_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt",       32'(gnt),       32'd0);
    check("async_busy",      32'(busy),      32'd0);
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_busy",  32'(busy),      32'd0);
    req     = 4'b0110;
    req_in1 = 4'b0010;
    req_in2 = 4'b0000;
    sb_q.push_back(model(4'b0010, 4'b0000, 1));
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    @(negedge clk);
    check("post_rst_rsp", 32'(rsp_valid), 32'd1);
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
